// File: rtl/ecall_uart_tx_if.sv
// rtl/ecall_uart_tx_if.sv - character handshake between the ECALL putchar service and the console transmitter
//
// Signals:
//   char_valid  producer presents a character this cycle
//   char_data   character byte (a1[7:0] of the ECALL)
//   char_ready  consumer can take the character (FIFO not full)
// Modports: master = producer (controller), slave = consumer (ecall_uart_tx).
interface ecall_uart_tx_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (output char_valid, output char_data, input char_ready);
  modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/ecall_uart_tx.sv
// rtl/ecall_uart_tx.sv - ECALL putchar console: character FIFO feeding an 8N1 UART transmitter
//
// Buffers characters pushed by the pipeline controller and shifts them out
// LSB first as UART frames on tx. After halt, drained reports that every
// buffered character has left the line.
//
// Optional feature macro: ECALL_UART_PARITY_EN adds an even-parity bit after
// the data bits (8E1 frame, 11 bit times instead of 10).
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   cif         slave side of the character handshake (valid/data/ready)
//   tx          registered serial line, idle high
//   tx_busy     a frame is in progress (FSM not in IDLE)
//   fifo_count  occupied FIFO entries
//   overflow    sticky: a character arrived while the FIFO was full
//   halt        core halt indication
//   drained     registered: halt seen, FIFO empty and FSM idle
module ecall_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  ecall_uart_tx_if.slave              cif,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        halt,
  output logic                        drained
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

`ifdef ECALL_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
`ifdef ECALL_UART_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q, halt_seen_q, drained_q;

  logic            push, pop, baud_last;

  // Ready comes from the count at the start of the cycle, so a pop in the
  // same cycle never frees a slot for a push.
  assign cif.char_ready = (count_q != FULL);
  assign push           = cif.char_valid && cif.char_ready;
  assign pop            = (state_q == S_IDLE) && (count_q != '0);
  assign baud_last      = (baud_q == BAUD_LAST);

  assign tx         = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drained    = drained_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cif.char_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      halt_seen_q <= 1'b0;
      drained_q   <= 1'b0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (cif.char_valid && !cif.char_ready) overflow_q <= 1'b1;
      if (halt) halt_seen_q <= 1'b1;
      drained_q <= halt_seen_q && (count_q == '0) && (state_q == S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef ECALL_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef ECALL_UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // tx_d is the line value for the next bit period, so tx stays registered.
  // The shift register is shifted at each data-bit boundary; shift_q[0] is
  // always the bit currently on the line and shift_q[1] the next one.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
`ifdef ECALL_UART_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (pop) begin
          shift_d = mem[rd_ptr_q];
`ifdef ECALL_UART_PARITY_EN
          parity_d = ^mem[rd_ptr_q];
`endif
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef ECALL_UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef ECALL_UART_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_ecall_uart_tx.sv
// tb/tb_ecall_uart_tx.sv - self-checking bench for ecall_uart_tx: line decoder plus expected-byte scoreboard
module tb_ecall_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef ECALL_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       halt;
  logic       tx, tx_busy, overflow, drained;
  logic [3:0] fifo_count;

  ecall_uart_tx_if cif ();

  ecall_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cif        (cif),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .halt       (halt),
    .drained    (drained)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_rx     = 0;
  logic [7:0] exp_q [$];
  int         start_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor: decode the serial line independently ----------
  logic samp [FRAME];
  int   mon_ns  = 0;
  bit   mon_inf = 1'b0;
  int   mon_cyc = 0;

  task automatic decode_frame();
    int         unstable;
    logic [FB-1:0] bits;
    logic [7:0] b, e;
    unstable = 0;
    for (int i = 0; i < FB; i++) begin
      bits[i] = samp[i*CPB];
      for (int k = 1; k < CPB; k++)
        if (samp[i*CPB+k] !== bits[i]) unstable++;
    end
    n_rx++;
    check("bit_stable", unstable, 0);
    check("start_bit", int'(bits[0]), 0);
    check("stop_bit", int'(bits[FB-1]), 1);
    b = bits[8:1];
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_frame: got 'h%02h expected no frame", b);
    end else begin
      e = exp_q.pop_front();
      check("frame_data", int'(b), int'(e));
`ifdef ECALL_UART_PARITY_EN
      check("parity_bit", int'(bits[9]), int'(^e));
`endif
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst) begin
        mon_inf = 1'b0;
      end else begin
        if (!mon_inf && tx == 1'b0) begin
          mon_inf = 1'b1;
          mon_ns  = 0;
          start_q.push_back(mon_cyc);
        end
        if (mon_inf) begin
          samp[mon_ns] = tx;
          mon_ns++;
          if (mon_ns == FRAME) begin
            mon_inf = 1'b0;
            decode_frame();
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    cif.char_valid = 1'b1;
    cif.char_data  = b;
    while (!cif.char_ready && guard < 2000) begin
      step();
      guard++;
    end
    if (guard >= 2000) check("send_timeout", guard, 0);
    else exp_q.push_back(b);
    step();
    cif.char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((fifo_count != 0 || tx_busy) && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) check("idle_timeout", guard, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, b;
    int cnt, bad, guard, idx0, rx0;

    rst = 1'b0; halt = 1'b0;
    cif.char_valid = 1'b0; cif.char_data = 8'h00;
    repeat (3) step();
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_drained", int'(drained), 0);
    check("rst_ready", int'(cif.char_ready), 1);
    rst = 1'b1;
    repeat (2) step();

    // Single character 0x41: tx falls one edge after the push edge.
    cif.char_valid = 1'b1; cif.char_data = 8'h41; exp_q.push_back(8'h41);
    step();
    cif.char_valid = 1'b0;
    check("tx_before_pop", int'(tx), 1);
    step();
    check("tx_start_edge1", int'(tx), 0);
    check("busy_edge1", int'(tx_busy), 1);
    cnt = 1;
    guard = 0;
    while (guard < 200) begin
      step();
      guard++;
      if (tx_busy) cnt++;
      else break;
    end
    check("busy_cycles", cnt, FRAME);
    check("tx_idle_after", int'(tx), 1);

    // Parity-sensitive bytes (even parity 1 and 0 when compiled in).
    send(8'h07);
    send(8'h03);
    wait_idle();

    // Push while popping: count stays 1, order preserved.
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    send(a);
    send(b);
    guard = 0;
    while (!(!tx_busy && fifo_count == 1) && guard < 500) begin
      step();
      guard++;
    end
    check("simul_setup", int'(fifo_count), 1);
    cif.char_valid = 1'b1; cif.char_data = 8'h55; exp_q.push_back(8'h55);
    step();
    cif.char_valid = 1'b0;
    check("simul_count", int'(fifo_count), 1);
    check("simul_tx_start", int'(tx), 0);
    wait_idle();

    // Random characters with random gaps.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 30)) step();
      send(8'($urandom_range(0, 255)));
    end
    wait_idle();
    check("random_drained_queue", exp_q.size(), 0);

    // Overflow: 10 consecutive valid cycles, 0x09 is dropped.
    repeat (2) step();
    idx0 = start_q.size();
    cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      cif.char_valid = 1'b1;
      cif.char_data  = 8'(i);
      if (i < 9) exp_q.push_back(8'(i));
      step();
      if (int'(fifo_count) > cnt) cnt = int'(fifo_count);
    end
    cif.char_valid = 1'b0;
    check("ovf_peak_count", cnt, DEPTH);
    check("ovf_sticky", int'(overflow), 1);
    wait_idle();
    check("ovf_queue_empty", exp_q.size(), 0);
    if (start_q.size() >= idx0 + 2) check("frame_spacing", start_q[idx0+1] - start_q[idx0], FRAME + 1);
    else check("frame_spacing_missing", start_q.size() - idx0, 2);
    check("ovf_still_set", int'(overflow), 1);

    // Halt drain.
    send(8'($urandom_range(0, 255)));
    send(8'($urandom_range(0, 255)));
    halt = 1'b1;
    step();
    halt = 1'b0;
    bad = 0; guard = 0;
    while ((fifo_count != 0 || tx_busy) && guard < 1000) begin
      if (drained) bad++;
      step();
      guard++;
    end
    check("drained_low_pending", bad, 0);
    check("drained_at_idle_edge", int'(drained), 0);
    step();
    check("drained_next_cycle", int'(drained), 1);
    cif.char_valid = 1'b1; cif.char_data = 8'h5A; exp_q.push_back(8'h5A);
    step();
    cif.char_valid = 1'b0;
    check("drained_push_edge", int'(drained), 1);
    step();
    check("drained_drop", int'(drained), 0);
    wait_idle();
    step();
    check("drained_again", int'(drained), 1);
    check("halt_queue_empty", exp_q.size(), 0);

    // Reset during DATA bit 3 with 3 bytes queued.
    for (int i = 0; i < 4; i++) begin
      cif.char_valid = 1'b1;
      cif.char_data  = 8'($urandom_range(0, 255));
      exp_q.push_back(cif.char_data);
      step();
    end
    cif.char_valid = 1'b0;
    check("rst_mid_queued", int'(fifo_count), 3);
    repeat (CPB*4 - 1) step();
    check("rst_mid_busy_before", int'(tx_busy), 1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_tx", int'(tx), 1);
    check("rst_mid_count", int'(fifo_count), 0);
    check("rst_mid_busy", int'(tx_busy), 0);
    check("rst_mid_overflow", int'(overflow), 0);
    check("rst_mid_drained", int'(drained), 0);
    step();
    rst = 1'b1;
    rx0 = n_rx;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("rst_no_frames_line", bad, 0);
    check("rst_no_frames_rx", n_rx - rx0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ecall_uart_tx.md
Name: ecall_uart_tx

Overview:
- Serial console transmitter that drains characters emitted by the pipeline controller's ECALL putchar service (a0 == 1, character in a1[7:0]).
- Sits beside the core. The controller pushes one byte per accepted ECALL; this block buffers the bytes in a small FIFO and shifts them out as 8N1 UART frames on a single tx line.
- Also reports when all buffered output has left the core after halt, so the testbench ends simulation only once the console is empty.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal values >= 2.
- FIFO_DEPTH, 8: character FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- char_valid  in  1  controller presents a character this cycle.
- char_data  in  8  character byte (a1[7:0]).
- char_ready  out  1  FIFO not full; combinational from the current count.
- tx  out  1  serial line, registered, idle high.
- tx_busy  out  1  FSM not in IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky: a character was dropped.
- halt  in  1  core halt indication.
- drained  out  1  halt seen, FIFO empty and FSM in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: tx=1, state=IDLE, FIFO empty, fifo_count=0, overflow=0, halt_seen=0, drained=0, bit/baud counters=0, shift register=0. char_ready=1 after reset.
- Reset mid-frame: tx returns to 1 immediately (asynchronous) and all queued characters are discarded.
- Push: occurs on an edge where char_valid && char_ready.
  - char_valid while full (char_ready=0): the byte is dropped and overflow is set. overflow clears only on reset.
  - char_ready reflects the count at the start of the cycle. A pop in the same cycle does not make room for a push.
- Pop: happens in IDLE when the FIFO is non-empty. At that edge the head is loaded into the shift register, state becomes START and tx is driven 0.
  - So tx falls one edge after the push edge when the FIFO was empty and the FSM was in IDLE.
- Simultaneous push and pop: count unchanged; pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE (tx=1).
  - START (tx=0, CLKS_PER_BIT cycles).
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - [PARITY]: only when the optional feature is compiled in.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then back to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. The bit and state advance when it reaches CLKS_PER_BIT-1. The bit index runs 0..7 in DATA.
- Frame timing: a frame is 10*CLKS_PER_BIT cycles. IDLE always lasts at least 1 cycle between frames, so back-to-back frame starts are 10*CLKS_PER_BIT+1 cycles apart.
- tx_busy: high from the edge entering START through the last STOP cycle.
- Halt handling:
  - halt_seen sets when halt=1 and stays set until reset.
  - Characters are still accepted after halt; drained drops while they are pending.
  - drained is a registered output: it asserts the cycle after halt_seen && count==0 && IDLE becomes true.

Optional Feature:
- Macro: ECALL_UART_PARITY_EN.
- Defined: a PARITY state follows DATA. tx carries the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 11*CLKS_PER_BIT cycles; start-to-start spacing becomes 11*CLKS_PER_BIT+1.
- Undefined: no PARITY state; the frame is exactly 10*CLKS_PER_BIT cycles (8N1).

Test Plan:
- Single character, CLKS_PER_BIT=4: push 0x41 at edge 0.
  - tx from edge 1 reads 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles.
  - tx_busy high 40 cycles; then IDLE with tx=1.
- Overflow, FIFO_DEPTH=8: char_valid held 10 consecutive cycles with data 0x00..0x09.
  - The first byte pops at edge 1, so 9 are accepted.
  - 0x09 is dropped; overflow=1; fifo_count peaks at 8.
  - Serial output is 0x00..0x08 in order.
- Simultaneous push/pop: count=1, FSM in IDLE, push 0x55 -> fifo_count stays 1; the next frame sends 0x55 after the current byte.
- Reset mid-frame: assert rst during DATA bit 3 with 3 bytes queued -> tx=1 at once, fifo_count=0, tx_busy=0; no further frames after release.
- Halt drain: queue 2 bytes, pulse halt -> drained=0 until the second STOP completes. drained=1 one cycle after IDLE with the FIFO empty; a new push drops drained to 0.
- With ECALL_UART_PARITY_EN, CLKS_PER_BIT=4: send 0x07 -> parity bit 1 and frame length 44 cycles. Send 0x03 -> parity bit 0.
